// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the data-memory store path.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  // Drain FSM states for the store unit.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } st_state_e;

endpackage

// File: rtl/store_fifo.sv
// Store buffer: DEPTH entries of {address, data}, FIFO ordered.
// Pointers carry one extra MSB so full and empty are distinguishable.
module store_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DW    = DATA_W,
  parameter int unsigned AW    = ADDR_W,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic [PW:0]   count
);

  localparam logic [PW:0] FullCnt = DEPTH[PW:0];

  logic [PW:0]   wptr_q, rptr_q;
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic          do_push, do_pop;

  assign count     = wptr_q - rptr_q;
  assign full      = (count == FullCnt);
  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push   = push && !full;
  assign do_pop    = pop && (count != '0);
  assign head_addr = addr_mem_q[rptr_q[PW-1:0]];
  assign head_data = data_mem_q[rptr_q[PW-1:0]];

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem_q[wptr_q[PW-1:0]] <= push_addr;
      data_mem_q[wptr_q[PW-1:0]] <= push_data;
    end
  end

  // Read/write pointers, wrapping modulo DEPTH with the extra wrap bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (PW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (PW+1)'(1);
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: buffers core stores and drains them to data memory over a
// req/ack write port, one word per transaction, strictly in order.
// Optional feature: define STORE_TIMEOUT_EN to drop a head entry that sees
// no ack within TIMEOUT request cycles (flagged by a one-cycle st_err).
module store_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DW      = DATA_W,
  parameter int unsigned AW      = ADDR_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  output logic          mem_wr_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          st_err
);

  st_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic          pop, full, expire;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  store_fifo #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (st_valid),
    .push_addr (st_addr),
    .push_data (st_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .count     (count)
  );

`ifdef STORE_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_q;

  assign expire = (tmo_q == TW'(TIMEOUT - 1));

  // Cycles spent in REQ; the mandatory IDLE cycle clears it before each request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= (state_q == ST_REQ) ? tmo_q + TW'(1) : '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire         = 1'b0;
`endif

  // st_ready looks only at the registered count, never at a same-cycle pop.
  assign st_ready   = !full;
  assign mem_wr_req = (state_q == ST_REQ);
  assign mem_addr   = addr_q;
  assign mem_wdata  = data_q;
  assign busy       = (count != '0) || (state_q == ST_REQ);
  assign st_err     = err_q;

  // Drain FSM: latch head in IDLE, hold it in REQ until ack (or timeout).
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pop     = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (count != '0) begin
          addr_d  = head_addr;
          data_d  = head_data;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (mem_ack) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else if (expire) begin
          pop     = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and registered memory-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_store_unit;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] st_addr = '0;
  logic [15:0] st_data = '0;
  logic        st_ready, mem_wr_req, busy, st_err;
  logic [15:0] mem_addr, mem_wdata;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  // Model: pending stores, plus the one currently offered to memory.
  ent_t        mq[$];
  bit          m_req = 1'b0;
  bit          m_err = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_data = '0;
  int          m_wait = 0;

  store_unit #(
    .DW      (16),
    .AW      (16),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_ready   (st_ready),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .count      (count),
    .st_err     (st_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the transaction-level model.
  task automatic model_step();
    bit   accept;
    ent_t e;
    accept = st_valid && (mq.size() < int'(DEPTH));
    e.a    = st_addr;
    e.d    = st_data;
    m_err  = 1'b0;
    if (m_req) begin
      if (mem_ack) begin
        void'(mq.pop_front());
        m_req = 1'b0;
      end
`ifdef STORE_TIMEOUT_EN
      else if (m_wait == int'(TIMEOUT) - 1) begin
        void'(mq.pop_front());
        m_req = 1'b0;
        m_err = 1'b1;
      end else begin
        m_wait++;
      end
`endif
    end else if (mq.size() != 0) begin
      m_req  = 1'b1;
      m_addr = mq[0].a;
      m_data = mq[0].d;
      m_wait = 0;
    end
    if (accept) mq.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_req  = 1'b0;
        m_err  = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_wait = 0;
      end else begin
        model_step();
      end
    end
  end

  // Every-cycle comparison against the model, 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        chk("mem_wr_req", mem_wr_req, m_req);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_data);
        chk("count", count, mq.size());
        chk("st_ready", st_ready, mq.size() < int'(DEPTH));
        chk("busy", busy, (mq.size() != 0) || m_req);
        chk("st_err", st_err, m_err);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to the next negedge; a store offered and accepted is withdrawn.
  task automatic tick();
    bit fire;
    fire = st_valid && st_ready;
    @(negedge clk);
    if (fire) st_valid = 1'b0;
  endtask

  task automatic offer(input logic [15:0] a, input logic [15:0] d);
    st_addr  = a;
    st_data  = d;
    st_valid = 1'b1;
    tick();
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!mem_wr_req && n < max) begin
      tick();
      n++;
    end
    chk("req_wait", mem_wr_req, 1);
  endtask

  task automatic ack_one(input string name, input logic [15:0] exp_data);
    wait_req(20);
    chk(name, mem_wdata, exp_data);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_wr_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", st_err, 0);

    // 1: reset asserted mid-request.
    offer(16'h0010, 16'hABCD);
    tick();
    chk("t1_req_up", mem_wr_req, 1);
    reset = 1'b1;
    #1;
    chk("t1_req_drop", mem_wr_req, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("t1_count", count, 0);
    chk("t1_st_ready", st_ready, 1);
    chk("t1_busy", busy, 0);

    // 2: single store, ack two cycles after the request rises.
    offer(16'h0020, 16'h1234);
    chk("t2_count1", count, 1);
    chk("t2_req_lat", mem_wr_req, 0);
    tick();
    chk("t2_req", mem_wr_req, 1);
    chk("t2_addr", mem_addr, 16'h0020);
    chk("t2_wdata", mem_wdata, 16'h1234);
    tick();
    chk("t2_hold_addr", mem_addr, 16'h0020);
    chk("t2_hold_wdata", mem_wdata, 16'h1234);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t2_req_low", mem_wr_req, 0);
    chk("t2_count0", count, 0);

    // 3: fill with no acks, then drain in order.
    for (int i = 1; i <= 4; i++) offer(16'h0100 + 16'(i), 16'(i));
    chk("t3_full_ready", st_ready, 0);
    chk("t3_full_count", count, 4);
    offer(16'h0105, 16'h0005);
    chk("t3_held_off", count, 4);
    chk("t3_held_valid", st_valid, 1);
    for (int i = 1; i <= 5; i++) ack_one("t3_order", 16'(i));
    chk("t3_empty", count, 0);
    chk("t3_idle", busy, 0);

    // 4: push and pop in the same cycle.
    offer(16'h0200, 16'h000A);
    offer(16'h0201, 16'h000B);
    chk("t4_count2", count, 2);
    chk("t4_head", mem_wdata, 16'h000A);
    st_addr  = 16'h0202;
    st_data  = 16'h000C;
    st_valid = 1'b1;
    mem_ack  = 1'b1;
    tick();
    mem_ack  = 1'b0;
    chk("t4_count_kept", count, 2);
    ack_one("t4_next", 16'h000B);
    ack_one("t4_last", 16'h000C);

    // 5: spurious ack while idle and empty.
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t5_count", count, 0);
    chk("t5_req", mem_wr_req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_addr", mem_addr, 16'h0202);

`ifdef STORE_TIMEOUT_EN
    // 6: timeout drop, then ack on the final allowed cycle.
    begin
      int n;
      offer(16'h0300, 16'h00E1);
      offer(16'h0301, 16'h00E2);
      wait_req(5);
      n = 0;
      while (mem_wr_req && n < 40) begin
        n++;
        tick();
      end
      chk("t6_req_cycles", n, TIMEOUT);
      chk("t6_err_pulse", st_err, 1);
      chk("t6_dropped", count, 1);
      tick();
      chk("t6_err_once", st_err, 0);
      wait_req(5);
      chk("t6_next", mem_wdata, 16'h00E2);
      for (int k = 1; k < int'(TIMEOUT); k++) tick();
      chk("t6_still_req", mem_wr_req, 1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("t6_ack_wins_req", mem_wr_req, 0);
      chk("t6_ack_wins_err", st_err, 0);
      chk("t6_ack_count", count, 0);
    end
`endif

    // Randomized traffic, with one reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_addr  = 16'($urandom);
      st_data  = 16'($urandom);
      mem_ack  = ($urandom_range(0, 2) == 0);
      if (i == 1000) reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    repeat (20) @(negedge clk);
    mem_ack  = 1'b0;
    chk("rand_drained", count, 0);
    chk("rand_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
